// File: rtl/quic_bs_pkg.sv
// Shared types and elaboration helpers for the quic_dec bitstream feeder.
package quic_bs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of OUT_W slices carried by one upstream word.
    function automatic int ratio_of(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // Index width that stays legal (>=1 bit) even for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/quic_bs_fifo.sv
// First-word-fall-through FIFO holding upstream words until they are sliced.
module quic_bs_fifo
    import quic_bs_pkg::*;
#(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         rd,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = idx_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          wr_en, rd_en;

    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rp_q];
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (wr_en) wp_d = wp_q + 1'b1;
            if (rd_en) rp_d = rp_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem_q[wp_q] <= wr_data;
    end

endmodule

// File: rtl/quic_bs_feeder.sv
// Bitstream front-end: buffers wide upstream words and presents them MSB-first
// as OUT_W-bit words over the decoder's we/next handshake for a programmed length.
module quic_bs_feeder
    import quic_bs_pkg::*;
#(
    parameter int IN_W  = 128,
    parameter int OUT_W = 32,
    parameter int DEPTH = 4,
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] num_words,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic [OUT_W-1:0] bitstream_input,
    output logic             we,
    input  logic             next,
    output logic             last_word,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] word_cnt
);

    localparam int RATIO = ratio_of(IN_W, OUT_W);
    localparam int SW    = idx_w(RATIO);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
    logic [LEN_W-1:0] fetch_left_q, fetch_left_d;
    logic [SW-1:0]    sidx_q, sidx_d;

    logic             fifo_full, fifo_empty;
    logic [IN_W-1:0]  fifo_head;
    logic [OUT_W-1:0] slices [RATIO];
    logic             start_acc, hs, final_word, pop, push, flush;
    logic [LEN_W-1:0] fetch_init;

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_slice
            assign slices[gi] = fifo_head[IN_W-1-gi*OUT_W -: OUT_W];
        end
    endgenerate

    assign start_acc  = (state_q == ST_IDLE) && start && !abort;
    assign final_word = (word_cnt_q == len_q - LEN_W'(1));
    assign hs         = we && next;
    assign pop        = hs && ((sidx_q == SW'(RATIO-1)) || final_word);
    assign push       = in_valid && in_ready;
    assign flush      = abort || start_acc;
    // Upstream fetches: ceil(num_words / RATIO), written to avoid overflow.
    assign fetch_init = LEN_W'(num_words / LEN_W'(RATIO))
                      + LEN_W'((num_words % LEN_W'(RATIO)) != '0);
    assign word_cnt   = word_cnt_q;

    quic_bs_fifo #(
        .W     (IN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (push),
        .wr_data (in_data),
        .rd      (pop),
        .flush   (flush),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            fetch_left_q <= '0;
            sidx_q       <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            fetch_left_q <= fetch_left_d;
            sidx_q       <= sidx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = (num_words == '0) ? ST_DONE : ST_RUN;
                ST_RUN:  if (hs && final_word) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // word_cnt keeps its value through abort so the partial count stays visible.
    always_comb begin
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        fetch_left_d = fetch_left_q;
        sidx_d       = sidx_q;
        if (abort) begin
            sidx_d = '0;
        end else if (start_acc) begin
            len_d        = num_words;
            word_cnt_d   = '0;
            fetch_left_d = fetch_init;
            sidx_d       = '0;
        end else if (state_q == ST_RUN) begin
            if (push) fetch_left_d = fetch_left_q - LEN_W'(1);
            if (hs) begin
                word_cnt_d = word_cnt_q + LEN_W'(1);
                sidx_d     = pop ? '0 : sidx_q + SW'(1);
            end
        end
    end

    always_comb begin
        busy            = (state_q == ST_RUN);
        done            = (state_q == ST_DONE);
        we              = busy && !fifo_empty;
        in_ready        = busy && !fifo_full && (fetch_left_q != '0);
        last_word       = we && final_word;
        bitstream_input = we ? slices[sidx_q] : '0;
    end

endmodule

// File: tb/tb_quic_bs_feeder.sv
// Self-checking bench for quic_bs_feeder: directed scenarios plus randomized
// streams compared every cycle against a stream-level reference model.
module tb_quic_bs_feeder;

    localparam int IN_W  = 128;
    localparam int OUT_W = 32;
    localparam int DEPTH = 4;
    localparam int LEN_W = 32;
    localparam int RATIO = IN_W / OUT_W;

    logic             clk = 1'b0;
    logic             reset_n, start, abort, in_valid, in_ready, we, next;
    logic             last_word, busy, done;
    logic [LEN_W-1:0] num_words, word_cnt;
    logic [IN_W-1:0]  in_data;
    logic [OUT_W-1:0] bitstream_input;

    always #5 clk = ~clk;

    quic_bs_feeder #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .num_words       (num_words),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .bitstream_input (bitstream_input),
        .we              (we),
        .next            (next),
        .last_word       (last_word),
        .busy            (busy),
        .done            (done),
        .word_cnt        (word_cnt)
    );

    int npass  = 0;
    int ntotal = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [IN_W-1:0] rw();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [OUT_W-1:0] slc(input logic [IN_W-1:0] w, input int s);
        return w[IN_W-1-s*OUT_W -: OUT_W];
    endfunction

    // Reference model: stream state, accepted upstream words, handshake count.
    int               m_st = 0;   // 0 idle, 1 run, 2 done
    int               m_len = 0, m_cnt = 0, m_fetched = 0;
    logic [IN_W-1:0]  m_acc[$];

    function automatic int ceil_div(input int a);
        return (a + RATIO - 1) / RATIO;
    endfunction
    function automatic int m_occ();
        return m_fetched - m_cnt / RATIO;
    endfunction
    function automatic bit m_in_ready();
        return (m_st == 1) && (m_occ() < DEPTH) && (m_fetched < ceil_div(m_len));
    endfunction
    function automatic bit m_we();
        return (m_st == 1) && (m_occ() > 0);
    endfunction
    function automatic logic [OUT_W-1:0] m_bits();
        if (!m_we()) return '0;
        return slc(m_acc[m_cnt / RATIO], m_cnt % RATIO);
    endfunction

    initial begin
        bit irdy, wev;
        forever begin
            @(posedge clk);
            irdy = m_in_ready();
            wev  = m_we();
            if (!reset_n) begin
                m_st = 0; m_cnt = 0; m_fetched = 0; m_acc.delete();
            end else if (abort) begin
                m_st = 0; m_fetched = 0; m_acc.delete();
            end else begin
                case (m_st)
                    0: if (start) begin
                        m_len = int'(num_words); m_cnt = 0; m_fetched = 0; m_acc.delete();
                        m_st = (m_len == 0) ? 2 : 1;
                    end
                    1: begin
                        if (in_valid && irdy) begin m_acc.push_back(in_data); m_fetched++; end
                        if (wev && next) begin
                            m_cnt++;
                            if (m_cnt == m_len) m_st = 2;
                        end
                    end
                    default: m_st = 0;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("in_ready", in_ready, m_in_ready());
                chk("we", we, m_we());
                chk("bitstream_input", bitstream_input, m_bits());
                chk("last_word", last_word, m_we() && (m_cnt == m_len - 1));
                chk("busy", busy, m_st == 1);
                chk("done", done, m_st == 2);
                chk("word_cnt", word_cnt, m_cnt);
            end
        end
    end

    // Transaction monitor for the directed literal checks.
    logic [OUT_W-1:0] seen[$];
    logic [OUT_W-1:0] last_seen;
    int               hs_cnt = 0, acc_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (we && next) begin
                seen.push_back(bitstream_input);
                if (last_word) last_seen = bitstream_input;
                hs_cnt++;
            end
            if (in_valid && in_ready) acc_cnt++;
        end
    end

    // Upstream source and decoder-side next driver.
    int              valid_mode = 0, next_mode = 0, nphase = 0;
    logic [IN_W-1:0] src_q[$];
    logic [IN_W-1:0] rnd_word;
    initial begin
        bit acc;
        in_valid = 1'b0;
        next     = 1'b0;
        rnd_word = rw();
        in_data  = rnd_word;
        forever begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                if (src_q.size() > 0) void'(src_q.pop_front());
                else rnd_word = rw();
            end
            in_data  = (src_q.size() > 0) ? src_q[0] : rnd_word;
            in_valid = (valid_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            case (next_mode)
                0: next = 1'b1;
                1: next = ($urandom_range(0, 1) == 1);
                2: begin nphase = (nphase + 1) % 3; next = (nphase == 0); end
                default: next = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1;
        num_words = LEN_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        chk({nm, "_done_seen"}, got, 1);
        tick();
    endtask

    task automatic clear_mon();
        seen.delete();
        hs_cnt = 0;
        acc_cnt = 0;
        last_seen = '0;
    endtask

    localparam logic [IN_W-1:0] W0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [IN_W-1:0] W1 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
    logic [OUT_W-1:0] exp8 [8] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
                                   32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    logic [IN_W-1:0]  fresh;

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; num_words = '0;
        repeat (3) tick();
        cmp_en = 1;
        chk("reset_outputs", {we, last_word, in_ready, busy, done, word_cnt, bitstream_input}, '0);
        reset_n = 1'b1;
        tick();

        // Basic stream
        src_q.delete(); src_q.push_back(W0); src_q.push_back(W1);
        valid_mode = 0; next_mode = 0; clear_mon();
        pulse_start(8);
        wait_done("basic", 200);
        chk("basic_count", seen.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < seen.size()) chk($sformatf("basic_word%0d", i), seen[i], exp8[i]);
        chk("basic_last", last_seen, 32'h0D0E0F10);

        // Partial final word
        src_q.delete(); src_q.push_back(W0); src_q.push_back(W1); clear_mon();
        pulse_start(6);
        wait_done("partial", 200);
        chk("partial_accepts", acc_cnt, 2);
        chk("partial_word_cnt", word_cnt, 6);
        chk("partial_count", seen.size(), 6);
        if (seen.size() == 6) chk("partial_last", seen[5], 32'h05060708);

        // Decoder backpressure: one next in three
        src_q.delete(); src_q.push_back(W0); src_q.push_back(W1);
        next_mode = 2; clear_mon();
        pulse_start(8);
        wait_done("bp", 300);
        chk("bp_count", seen.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < seen.size()) chk($sformatf("bp_word%0d", i), seen[i], exp8[i]);

        // FIFO full
        src_q.delete(); next_mode = 3; clear_mon();
        pulse_start(16);
        repeat (11) tick();
        chk("full_accepts", acc_cnt, 4);
        chk("full_in_ready", in_ready, 0);
        next_mode = 0;
        wait_done("full", 300);
        chk("full_count", seen.size(), 16);

        // Abort after three handshakes, then restart from fresh data
        src_q.delete(); clear_mon();
        pulse_start(16);
        for (int i = 0; i < 100 && hs_cnt < 3; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_we", we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_word_cnt", word_cnt, 3);
        fresh = rw();
        src_q.delete(); src_q.push_back(fresh); clear_mon();
        pulse_start(4);
        wait_done("restart", 200);
        chk("restart_count", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("restart_first", seen[0], slc(fresh, 0));
            chk("restart_fourth", seen[3], slc(fresh, 3));
        end

        // Zero length
        clear_mon();
        pulse_start(0);
        chk("zero_done", done, 1);
        chk("zero_we", we, 0);
        tick();
        chk("zero_done_drop", done, 0);
        chk("zero_no_words", seen.size(), 0);

        // Reset mid-stream
        src_q.delete();
        pulse_start(20);
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        chk("midreset_outputs", {we, last_word, in_ready, busy, done, word_cnt, bitstream_input}, '0);
        reset_n = 1'b1;
        tick();

        // Randomized back-to-back streams
        for (int s = 0; s < 40; s++) begin
            int len;
            len = $urandom_range(0, 40);
            valid_mode = $urandom_range(0, 1);
            next_mode  = $urandom_range(0, 2);
            src_q.delete();
            pulse_start(len);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, 20)) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end else begin
                if (len >= 4 && $urandom_range(0, 1) == 1) begin
                    start = 1'b1;
                    num_words = LEN_W'($urandom_range(1, 9));
                    tick();
                    start = 1'b0;
                end
                wait_done($sformatf("rand%0d", s), 3000);
            end
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/quic_bs_feeder.md
# quic_bs_feeder

Parametrised bitstream front-end for `quic_dec`. It accepts wide words from an upstream memory or bus port and buffers them in a small FIFO. It slices them MSB-first into `OUT_W`-bit bitstream words and presents them over the decoder's `we`/`next` handshake. It counts a programmed stream length, generates `last_word` on the final word, and supports abort and back-to-back restart for multi-image runs.

## Interface
Parameters:
- `IN_W`, 128, upstream word width; must be an integer multiple of `OUT_W`
- `OUT_W`, 32, bitstream word width presented to the decoder
- `DEPTH`, 4, FIFO depth in `IN_W` entries (power of two, ≥2)
- `LEN_W`, 32, width of length and word counters

Ports:
- `clk`  in  1  single clock
- `reset_n`  in  1  reset, synchronous and active-low
- `start`  in  1  one-cycle pulse; begins a stream (ignored unless IDLE)
- `abort`  in  1  terminates any stream; highest priority after reset
- `num_words`  in  LEN_W  stream length in `OUT_W` words, sampled on `start`
- `in_valid`  in  1  upstream word valid
- `in_data`  in  IN_W  upstream word; bits [IN_W-1 -: OUT_W] are the first slice
- `in_ready`  out  1  upstream accept; transfer when `in_valid && in_ready`
- `bitstream_input`  out  OUT_W  current bitstream word to decoder
- `we`  out  1  `bitstream_input` valid
- `next`  in  1  decoder accepts; transfer when `we && next`
- `last_word`  out  1  high with `we` while the final word of the stream is presented
- `busy`  out  1  state is RUN
- `done`  out  1  one-cycle pulse at stream completion
- `word_cnt`  out  LEN_W  words transferred to decoder in current stream

## Operation
- States are IDLE, RUN and DONE.
  - IDLE→RUN on `start`. `num_words` is latched into `len`, and `word_cnt`, `fetch_left` and the FIFO are cleared. `fetch_left = ceil(len/RATIO)`, where `RATIO = IN_W/OUT_W`.
  - IDLE→DONE on `start` with `num_words==0`. No word is presented.
  - RUN→DONE on the handshake of the final word (`word_cnt==len-1`).
  - DONE→IDLE unconditionally after one cycle. `done` is high only in DONE.
  - `abort` in any state → IDLE next cycle. The FIFO is flushed, the slice index is cleared, and `done` is not pulsed.
- `in_ready = RUN && !fifo_full && fetch_left!=0`. There is no same-cycle pop bypass. Each accepted upstream word decrements `fetch_left`.
- `we = RUN && !fifo_empty`. `bitstream_input` = slice `sidx` of the FIFO head, MSB-first. It is 0 when `we` is low.
- On each handshake:
  - `word_cnt` increments.
  - `sidx` increments.
  - The head is popped, and `sidx` returns to 0, when `sidx==RATIO-1` or the word was the final word.
  - Unused trailing slices of the final upstream word are discarded.
- `last_word = we && (word_cnt==len-1)`.
- `start` while RUN or DONE is ignored. `start` and `abort` in the same cycle: abort wins.
- Upstream words offered after `fetch_left` reaches 0 are never accepted.

## Timing
- Reset (`reset_n` low at a `clk` edge) forces the following on the next cycle:
  - state IDLE
  - `we`, `last_word`, `in_ready`, `busy`, `done` all 0
  - `word_cnt` 0, `bitstream_input` 0
  - FIFO empty
- Reset mid-stream behaves like abort.
- `start` at cycle t: `busy` and `in_ready` are high from t+1.
- Upstream accept at cycle n into an empty FIFO: `we` is high at n+1.
- Sustained throughput is one `OUT_W` word per cycle while `next` is high. Upstream needs one accept per `RATIO` cycles.
- `bitstream_input` and `last_word` are held stable while `we && !next`.
- Final handshake at cycle f: `done`=1 and `we`=0 at f+1; IDLE at f+2, where a new `start` is accepted.
- FIFO full: `in_ready` drops the cycle after the `DEPTH`-th write without a pop. It rises the cycle after the first pop.

## Structure
- Package `quic_bs_pkg` holds:
  - the state enum (IDLE/RUN/DONE)
  - `RATIO` derivation helper
  - a `clog2`-based index width function
- One sub-module, `quic_bs_fifo`: synchronous FIFO, `IN_W`×`DEPTH`, with the following interface:
  - `wr`, `rd`, `flush`
  - `full`, `empty`, `head` (first-word-fall-through)
  - synchronous active-low reset
- The top level holds the FSM, counters, slice mux and handshake logic.

## Test plan
- **Basic stream.** Defaults, `num_words`=8, `next`≡1, upstream words `0x00112233_44556677_8899AABB_CCDDEEFF` and `0x01020304_05060708_090A0B0C_0D0E0F10` → `bitstream_input` sequence `00112233,44556677,…,0D0E0F10` on consecutive cycles. `last_word` is high only with `0D0E0F10`, and `done` pulses the next cycle.
- **Partial final word.** `num_words`=6 → exactly 2 upstream accepts. Slices 2–3 of the second word are never presented. `in_ready` stays 0 after the second accept despite `in_valid`=1. `word_cnt` ends at 6.
- **Decoder backpressure.** `next` high one cycle in three → `bitstream_input`/`last_word` are unchanged during stalls, `word_cnt` increments only on handshakes, and the output sequence is identical to the `next`≡1 case.
- **FIFO full.** `next`=0 for 12 cycles after `start` → 4 accepts then `in_ready`=0. After `next` rises, `in_ready` returns one cycle after the 4th slice handshake.
- **Abort and restart.** `abort` after 3 handshakes → next cycle `we`=0, `busy`=0, FIFO empty, no `done`. A new `start` with `num_words`=4 replays from fresh upstream data, starting at slice 0.
- **Zero length and reset.** `start` with `num_words`=0 → `done` at t+1 and `we` never asserted. `reset_n` low mid-stream → all outputs 0 the next cycle.
